input_sr: RTL and testbench

Input-side packing shift register for the CGRA memory datapath, the write-side counterpart of the 32-bit-to-16-bit output shift register. It accepts one 16-bit word per cycle from the tile datapath into a small circular buffer, and lets a 32-bit consumer pop one word or two packed words per request. Popped data is returned registered, with a one-cycle `valid` strobe.

---
 rtl/input_sr.sv | 125 ++++++++++++
 tb/tb_input_sr.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/input_sr.sv
// Input-side packing shift register: 16-bit pushes into a circular buffer, 1- or 2-word registered pops.
// Optional sticky overflow/underflow flags are built when INPUT_SR_ERR_EN is defined.
module input_sr #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DWIDTH-1:0]          data_in,
    input  logic                       wen,
    output logic                       full,
    input  logic                       ren_w1,
    input  logic                       ren_w2,
    output logic                       avail_w1,
    output logic                       avail_w2,
    output logic [2*DWIDTH-1:0]        data_out,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic [1:0]                 err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] TWO_C   = (AW+1)'(2);

    logic [DWIDTH-1:0]   mem_r [DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [AW:0]         count_r;
    logic [2*DWIDTH-1:0] data_out_r;
    logic                valid_r;

    logic                push_s;
    logic                pop1_s;
    logic                pop2_s;
    logic [AW-1:0]       rd_ptr_p1_s;
    logic [AW:0]         count_nxt_s;

    // Accept/reject decisions, all taken from the registered occupancy
    always_comb begin
        push_s      = wen && (count_r < DEPTH_C);
        pop2_s      = ren_w2 && (count_r >= TWO_C);
        pop1_s      = !ren_w2 && ren_w1 && (count_r >= ONE_C);
        rd_ptr_p1_s = rd_ptr_r + AW'(1);
        count_nxt_s = count_r;
        if (push_s) begin
            count_nxt_s = count_nxt_s + ONE_C;
        end else begin
            count_nxt_s = count_nxt_s;
        end
        if (pop2_s) begin
            count_nxt_s = count_nxt_s - TWO_C;
        end else if (pop1_s) begin
            count_nxt_s = count_nxt_s - ONE_C;
        end else begin
            count_nxt_s = count_nxt_s;
        end
    end

    // Storage array; intentionally not reset, writes suppressed during reset
    always_ff @(posedge clk) begin
        if (reset && push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy and registered pop data
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            data_out_r <= '0;
            valid_r    <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop2_s) begin
                data_out_r <= {mem_r[rd_ptr_p1_s], mem_r[rd_ptr_r]};
                rd_ptr_r   <= rd_ptr_r + AW'(2);
                valid_r    <= 1'b1;
            end else if (pop1_s) begin
                data_out_r <= {{DWIDTH{1'b0}}, mem_r[rd_ptr_r]};
                rd_ptr_r   <= rd_ptr_p1_s;
                valid_r    <= 1'b1;
            end else begin
                valid_r    <= 1'b0;
            end
        end
    end

`ifdef INPUT_SR_ERR_EN
    logic [1:0] err_r;

    // Sticky overflow (bit 0) and underflow (bit 1) flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_r <= 2'b00;
        end else begin
            if (wen && (count_r == DEPTH_C)) begin
                err_r[0] <= 1'b1;
            end
            if ((ren_w2 && (count_r < TWO_C)) ||
                (ren_w1 && !ren_w2 && (count_r == '0))) begin
                err_r[1] <= 1'b1;
            end
        end
    end

    assign err = err_r;
`else
    assign err = 2'b00;
`endif

    assign full     = (count_r == DEPTH_C);
    assign avail_w1 = (count_r >= ONE_C);
    assign avail_w2 = (count_r >= TWO_C);
    assign data_out = data_out_r;
    assign valid    = valid_r;
    assign count    = count_r;

endmodule

// File: tb/tb_input_sr.sv
// Randomized bench for input_sr, checked every cycle against a word-queue reference model.
module tb_input_sr;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          wen;
    logic          ren_w1;
    logic          ren_w2;
    logic          full;
    logic          avail_w1;
    logic          avail_w2;
    logic [2*DW-1:0] data_out;
    logic          valid;
    logic [2:0]    count;
    logic [1:0]    err;

    input_sr #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .wen(wen), .full(full),
        .ren_w1(ren_w1), .ren_w2(ren_w2), .avail_w1(avail_w1), .avail_w2(avail_w2),
        .data_out(data_out), .valid(valid), .count(count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0]   q[$];
    logic [2*DW-1:0] exp_dout;
    logic            exp_valid;
    logic [1:0]      exp_err;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("count", 64'(count), 64'(q.size()));
        check_val("full", 64'(full), 64'(q.size() == DEPTH));
        check_val("avail_w1", 64'(avail_w1), 64'(q.size() >= 1));
        check_val("avail_w2", 64'(avail_w2), 64'(q.size() >= 2));
        check_val("valid", 64'(valid), 64'(exp_valid));
        check_val("data_out", 64'(data_out), 64'(exp_dout));
        check_val("err", 64'(err), 64'(exp_err));
    endtask

    // Apply one cycle of inputs, advance the model at the edge, check at the falling edge
    task automatic cycle(input logic rst_v, input logic wen_v, input logic [DW-1:0] d,
                         input logic r1, input logic r2);
        int n;
        reset = rst_v; wen = wen_v; data_in = d; ren_w1 = r1; ren_w2 = r2;
        @(posedge clk);
        n = q.size();
        if (!rst_v) begin
            q.delete();
            exp_dout = '0; exp_valid = 1'b0; exp_err = 2'b00;
        end else begin
`ifdef INPUT_SR_ERR_EN
            if (wen_v && n == DEPTH) exp_err[0] = 1'b1;
            if ((r2 && n < 2) || (r1 && !r2 && n == 0)) exp_err[1] = 1'b1;
`endif
            exp_valid = 1'b0;
            if (r2) begin
                if (n >= 2) begin
                    exp_dout = {q[1], q[0]};
                    void'(q.pop_front()); void'(q.pop_front());
                    exp_valid = 1'b1;
                end
            end else if (r1 && n >= 1) begin
                exp_dout = {16'h0000, q[0]};
                void'(q.pop_front());
                exp_valid = 1'b1;
            end
            if (wen_v && n < DEPTH) q.push_back(d);
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        exp_dout = '0; exp_valid = 1'b0; exp_err = 2'b00;
        reset = 1'b0; wen = 1'b0; data_in = '0; ren_w1 = 1'b0; ren_w2 = 1'b0;

        // basic pop2
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        check_val("pop2_data", 64'(data_out), 64'h22221111);

        // pop1 then underflow pop1
        cycle(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        check_val("pop1_data", 64'(data_out), 64'h0000AAAA);
        cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        check_val("empty_pop_valid", 64'(valid), 64'h0);
        check_val("empty_pop_hold", 64'(data_out), 64'h0000AAAA);

        // overflow
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 1'b1, DW'(i), 1'b0, 1'b0);
            if (i >= 4) check_val("full_after_4", 64'(full), 64'h1);
        end
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        check_val("ovf_pop2_a", 64'(data_out), 64'h00020001);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        check_val("ovf_pop2_b", 64'(data_out), 64'h00040003);

        // wrap-around
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h00A1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h00A2, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h00A3, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 16'h00A4, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h00A5, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        check_val("wrap_pop2_a", 64'(data_out), 64'h00A300A2);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        check_val("wrap_pop2_b", 64'(data_out), 64'h00A500A4);

        // simultaneous push/pop
        cycle(1'b1, 1'b1, 16'h0B01, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h0B02, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h0B03, 1'b1, 1'b0);
        check_val("push_pop1_count", 64'(count), 64'h2);
        check_val("push_pop1_data", 64'(data_out), 64'h00000B01);
        cycle(1'b1, 1'b1, 16'h0B04, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h0B05, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h0B06, 1'b0, 1'b1);
        check_val("full_push_pop2_count", 64'(count), 64'h2);

        // reset mid-operation with a pending pop2
        cycle(1'b1, 1'b1, 16'h0C01, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        check_val("rst_count", 64'(count), 64'h0);
        check_val("rst_dout", 64'(data_out), 64'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic rv, wv, r1v, r2v;
            rv  = ($urandom_range(0, 99) != 0);
            wv  = ($urandom_range(0, 99) < 60);
            r1v = ($urandom_range(0, 99) < 35);
            r2v = ($urandom_range(0, 99) < 25);
            cycle(rv, wv, DW'($urandom), r1v, r2v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
